// File: rtl/uart_tx_core_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_core_pkg
// Shared definitions for the UART transmit core: FSM state encoding, the
// default oversampling ratio and the parity mode constants.
// -----------------------------------------------------------------------------
package uart_tx_core_pkg;

    // Transmit FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Oversample ticks per bit time supplied by the tick generator.
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Value XORed into the data reduction to form the parity bit.
    localparam logic PARITY_MODE_EVEN = 1'b0;
    localparam logic PARITY_MODE_ODD  = 1'b1;

endpackage : uart_tx_core_pkg

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Serialises parallel words onto the UART TX line. Each baud_tick_i pulse is
// one oversample tick; a bit lasts OVERSAMPLE ticks. Frame: start bit, data
// LSB first, optional parity bit, one or two stop bits.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   baud_tick_i  1-cycle oversample pulse from the tick generator
//   tx_data_i    word to send
//   tx_valid_i   tx_data_i valid
//   tx_ready_o   core can accept a word (high only in IDLE)
//   tx_o         serial line, idle high, registered
//   tx_busy_o    frame in progress
//   tx_done_o    1-cycle pulse at the end of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_core
    import uart_tx_core_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic                  tx_o,
    output logic                  tx_busy_o,
    output logic                  tx_done_o
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD
                                                                : PARITY_MODE_EVEN;

    tx_state_e             state_q,    state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  parity_q,   parity_d;
    logic                  tx_q,       tx_d;
    logic                  tx_done_q,  tx_done_d;
    logic                  bit_end;

    assign tx_ready_o = (state_q == ST_IDLE);
    assign tx_busy_o  = (state_q != ST_IDLE);
    assign tx_o       = tx_q;
    assign tx_done_o  = tx_done_q;

    // Last oversample tick of the current bit.
    assign bit_end = baud_tick_i && (tick_cnt_q == TICK_LAST);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the case statement can leave one unassigned (no latches).
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_done_d  = 1'b0;
        tx_d       = 1'b1;

        // Ticks only advance bit timing while a frame is in flight.
        if (state_q != ST_IDLE && baud_tick_i) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + TICK_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    state_d    = ST_START;
                    shift_d    = tx_data_i;
                    parity_d   = (^tx_data_i) ^ PAR_MODE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = ST_IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The line is registered from the next state so it changes on the
        // same edge as the state: one cycle from handshake to start bit.
        unique case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous (only at a clk edge).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

endmodule : uart_tx_core

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
// Four cores share clock, reset, tick and data: 8N1, 8E1, 8O1 and 8N2. Each
// has its own valid. baud_tick pulses once every 4 clk. Everything is sampled
// and driven on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       valid_v [4];
    logic       ready_w [4];
    logic       tx_w    [4];
    logic       busy_w  [4];
    logic       done_w  [4];

    int total = 0;
    int bad   = 0;
    int phase = 0;
    int ticks_seen = 0;
    bit tick_now = 1'b0;

    always #5 clk = ~clk;

    uart_tx_core #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .baud_tick_i(baud_tick), .tx_data_i(tx_data),
        .tx_valid_i(valid_v[0]), .tx_ready_o(ready_w[0]), .tx_o(tx_w[0]),
        .tx_busy_o(busy_w[0]), .tx_done_o(done_w[0]));

    uart_tx_core #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .baud_tick_i(baud_tick), .tx_data_i(tx_data),
        .tx_valid_i(valid_v[1]), .tx_ready_o(ready_w[1]), .tx_o(tx_w[1]),
        .tx_busy_o(busy_w[1]), .tx_done_o(done_w[1]));

    uart_tx_core #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .baud_tick_i(baud_tick), .tx_data_i(tx_data),
        .tx_valid_i(valid_v[2]), .tx_ready_o(ready_w[2]), .tx_o(tx_w[2]),
        .tx_busy_o(busy_w[2]), .tx_done_o(done_w[2]));

    uart_tx_core #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .baud_tick_i(baud_tick), .tx_data_i(tx_data),
        .tx_valid_i(valid_v[3]), .tx_ready_o(ready_w[3]), .tx_o(tx_w[3]),
        .tx_busy_o(busy_w[3]), .tx_done_o(done_w[3]));

    // One frame vector: which core, the word, frame length in bits and the
    // expected line value per bit (bit 0 = start bit).
    typedef struct {
        int         dut;
        logic [7:0] data;
        int         nbits;
        logic [11:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Advance to the next falling edge, note whether the rising edge just
    // passed saw a tick, then set up the tick for the following rising edge.
    task automatic cyc();
        @(negedge clk);
        tick_now = baud_tick;
        if (tick_now) ticks_seen++;
        phase = (phase + 1) % 4;
        baud_tick = (phase == 0);
    endtask

    // Present a word to core d and step through the handshake edge.
    task automatic start(input int d, input logic [7:0] data, input bit hold);
        tx_data = data;
        valid_v[d] = 1'b1;
        cyc();
        if (!hold) valid_v[d] = 1'b0;
        ticks_seen = 0;
        check("start_tx_low", {31'd0, tx_w[d]}, 32'd0);
        check("start_busy", {31'd0, busy_w[d]}, 32'd1);
        check("start_not_ready", {31'd0, ready_w[d]}, 32'd0);
        check("start_no_done", {31'd0, done_w[d]}, 32'd0);
    endtask

    // Follow a frame: mid-bit line checks, then tx_done exactly at the last tick.
    // Returns on the falling edge where tx_done is high.
    task automatic run_frame(input int d, input logic [11:0] exp, input int nbits, input bit toggle);
        int  early = 0;
        bit  hit = 1'b0;
        int  t;
        for (int c = 0; c < nbits * OS * 4 + 64; c++) begin
            cyc();
            if (toggle) tx_data = 8'($urandom);
            t = ticks_seen;
            if (tick_now && t == nbits * OS) begin
                check("done_pulse", {31'd0, done_w[d]}, 32'd1);
                check("done_ready", {31'd0, ready_w[d]}, 32'd1);
                check("done_not_busy", {31'd0, busy_w[d]}, 32'd0);
                check("done_tx_idle", {31'd0, tx_w[d]}, 32'd1);
                hit = 1'b1;
                break;
            end
            if (done_w[d]) early++;
            if (tick_now && (t % OS) == OS / 2) begin
                check($sformatf("bit%0d", t / OS), {31'd0, tx_w[d]}, {31'd0, exp[t / OS]});
                check("mid_busy", {31'd0, busy_w[d]}, 32'd1);
            end
        end
        if (!hit) check("frame_timeout", 32'd0, 32'd1);
        check("no_early_done", early, 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        int lows;
        int dones;
        bit reached;

        vecs[0] = '{0, 8'h55, 10, 12'h2AA};
        vecs[1] = '{0, 8'h00, 10, 12'h200};
        vecs[2] = '{0, 8'hFF, 10, 12'h3FE};
        vecs[3] = '{1, 8'h07, 11, 12'h60E};
        vecs[4] = '{2, 8'h07, 11, 12'h40E};
        vecs[5] = '{1, 8'h00, 11, 12'h400};
        vecs[6] = '{2, 8'h00, 11, 12'h600};
        vecs[7] = '{3, 8'hA3, 11, 12'h746};
        vecs[8] = '{3, 8'h01, 11, 12'h602};

        for (int i = 0; i < 4; i++) valid_v[i] = 1'b0;

        // Reset state.
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rst_tx", {31'd0, tx_w[i]}, 32'd1);
            check("rst_busy", {31'd0, busy_w[i]}, 32'd0);
            check("rst_done", {31'd0, done_w[i]}, 32'd0);
            check("rst_ready", {31'd0, ready_w[i]}, 32'd1);
        end
        // Ticks while idle must not start anything.
        for (int c = 0; c < 12; c++) cyc();
        check("idle_tx", {31'd0, tx_w[0]}, 32'd1);
        check("idle_ready", {31'd0, ready_w[0]}, 32'd1);

        // Table-driven frames.
        foreach (vecs[i]) begin
            start(vecs[i].dut, vecs[i].data, 1'b0);
            run_frame(vecs[i].dut, vecs[i].exp, vecs[i].nbits, 1'b0);
            cyc();
            check("after_done_low", {31'd0, done_w[vecs[i].dut]}, 32'd0);
            check("after_idle_tx", {31'd0, tx_w[vecs[i].dut]}, 32'd1);
            for (int c = 0; c < 5; c++) cyc();
        end

        // Back-to-back: valid held; second word taken one clk after tx_done.
        start(0, 8'h01, 1'b1);
        run_frame(0, 12'h202, 10, 1'b0);
        tx_data = 8'h80;
        start(0, 8'h80, 1'b0);
        run_frame(0, 12'h300, 10, 1'b0);
        for (int c = 0; c < 5; c++) cyc();

        // Reset during data bit 3 (frame bit 4).
        start(0, 8'h55, 1'b0);
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            cyc();
            if (ticks_seen == 4 * OS + OS / 2) begin
                reached = 1'b1;
                break;
            end
        end
        check("reach_bit3", {31'd0, reached}, 32'd1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("midrst_tx", {31'd0, tx_w[0]}, 32'd1);
        check("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
        check("midrst_ready", {31'd0, ready_w[0]}, 32'd1);
        lows = 0;
        dones = 0;
        for (int c = 0; c < 10 * OS * 4; c++) begin
            cyc();
            if (done_w[0]) dones++;
            if (!tx_w[0]) lows++;
        end
        check("midrst_no_done", dones, 32'd0);
        check("midrst_tx_high", lows, 32'd0);

        // Busy: valid stays high, data churns; transmitted word unchanged.
        start(3, 8'hA3, 1'b1);
        run_frame(3, 12'h746, 11, 1'b1);
        valid_v[3] = 1'b0;
        cyc();
        check("busy_no_restart", {31'd0, busy_w[3]}, 32'd0);
        check("busy_tx_idle", {31'd0, tx_w[3]}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_core
